// File: rtl/usb_pkg.sv
// Shared constants and state encoding for the full-speed USB transmitter.
package usb_pkg;

  // Line state as {dp, dn}.
  typedef logic [1:0] line_t;

  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;
  localparam int         EOP_SE0_BITS = 2;
  localparam int         EOP_J_BITS   = 1;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } tx_state_t;

endpackage

// File: rtl/usb_tx_if.sv
// Byte-stream handshake between a packet source and the USB transmitter.
interface usb_tx_if;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_last, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_last, input tx_valid, output tx_ready);
endinterface

// File: rtl/usb_tx_nrzi.sv
// NRZI line encoder with consecutive-ones tracking for bit stuffing.
module usb_tx_nrzi
  import usb_pkg::*;
(
  input  logic  clk48,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  send,
  input  logic  bit_in,
  output line_t line,
  output logic  stuff_req
);

  logic [2:0] ones;

  // A send always wins over clr so the first SYNC bit encodes from J.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      line <= LINE_J;
      ones <= 3'd0;
    end else if (send) begin
      if (!bit_in) begin
        line <= (line == LINE_J) ? LINE_K : LINE_J;
        ones <= 3'd0;
      end else begin
        ones <= ones + 3'd1;
      end
    end else if (clr) begin
      line <= LINE_J;
      ones <= 3'd0;
    end
  end

  assign stuff_req = (ones == STUFF_LIMIT);

endmodule

// File: rtl/usb_tx.sv
// Full-speed USB packet transmitter: SYNC, NRZI data with bit stuffing, EOP.
module usb_tx
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic     clk48,
  input  logic     rst_n,
  usb_tx_if.slave  tx,
  output logic     usb_dp_out,
  output logic     usb_dn_out,
  output logic     usb_oe,
  output logic     tx_busy,
  output logic     tx_underrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_RELOAD = CW'(CLKS_PER_BIT - 1);

  tx_state_t state, state_d;

  logic [CW-1:0] clk_cnt;
  logic [7:0]    hold, sh;
  logic          hold_last, hold_valid, sh_last, rdy_en;
  logic [3:0]    sh_cnt;
  logic [1:0]    eop_cnt, eop_val;

  logic  strobe, fire, stuff_req, nrzi_send, nrzi_bit, nrzi_clr;
  logic  load_sync, take_hold, hold_send, pop, eop_load, eop_dec, underrun_set;
  line_t line, out_line;

  assign strobe      = (state != IDLE) && (clk_cnt == '0);
  assign tx.tx_ready = rdy_en && !hold_valid && (state != EOP_SE0) && (state != EOP_J);
  assign fire        = tx.tx_valid && tx.tx_ready;
  assign nrzi_clr    = (state == IDLE) || (state == EOP_SE0) || (state == EOP_J);

  usb_tx_nrzi u_nrzi (
    .clk48     (clk48),
    .rst_n     (rst_n),
    .clr       (nrzi_clr),
    .send      (nrzi_send),
    .bit_in    (nrzi_bit),
    .line      (line),
    .stuff_req (stuff_req)
  );

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d      = state;
    load_sync    = 1'b0;
    take_hold    = 1'b0;
    hold_send    = 1'b0;
    pop          = 1'b0;
    nrzi_send    = 1'b0;
    nrzi_bit     = 1'b0;
    eop_load     = 1'b0;
    eop_val      = 2'd0;
    eop_dec      = 1'b0;
    underrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (fire || hold_valid) begin
          state_d   = SYNC;
          load_sync = 1'b1;
          nrzi_send = 1'b1;
          nrzi_bit  = SYNC_BYTE[0];
        end
      end
      SYNC, DATA: begin
        if (strobe) begin
          if (stuff_req) begin
            // Stuff bit goes out, but a waiting byte still moves up now.
            nrzi_send = 1'b1;
            if (sh_cnt == 4'd0 && hold_valid && !sh_last) begin
              take_hold = 1'b1;
              state_d   = DATA;
            end
          end else if (sh_cnt != 4'd0) begin
            pop       = 1'b1;
            nrzi_send = 1'b1;
            nrzi_bit  = sh[0];
          end else if (!sh_last && hold_valid) begin
            take_hold = 1'b1;
            hold_send = 1'b1;
            nrzi_send = 1'b1;
            nrzi_bit  = hold[0];
            state_d   = DATA;
          end else begin
            state_d      = EOP_SE0;
            eop_load     = 1'b1;
            eop_val      = 2'(EOP_SE0_BITS - 1);
            underrun_set = !sh_last;
          end
        end
      end
      EOP_SE0: begin
        if (strobe) begin
          if (eop_cnt == 2'd0) begin
            state_d  = EOP_J;
            eop_load = 1'b1;
            eop_val  = 2'(EOP_J_BITS - 1);
          end else begin
            eop_dec = 1'b1;
          end
        end
      end
      EOP_J: begin
        if (strobe) begin
          if (eop_cnt == 2'd0) state_d = IDLE;
          else                 eop_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    usb_oe   = (state != IDLE);
    tx_busy  = (state != IDLE);
    out_line = LINE_J;
    if (state == EOP_SE0)                      out_line = LINE_SE0;
    else if (state == SYNC || state == DATA)   out_line = line;
    {usb_dp_out, usb_dn_out} = out_line;
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en      <= 1'b0;
      clk_cnt     <= CLK_RELOAD;
      hold        <= 8'd0;
      hold_last   <= 1'b0;
      hold_valid  <= 1'b0;
      sh          <= 8'd0;
      sh_cnt      <= 4'd0;
      sh_last     <= 1'b0;
      eop_cnt     <= 2'd0;
      tx_underrun <= 1'b0;
    end else begin
      rdy_en      <= 1'b1;
      tx_underrun <= underrun_set;
      if (state == IDLE || strobe) clk_cnt <= CLK_RELOAD;
      else                         clk_cnt <= clk_cnt - 1'b1;

      if (fire) begin
        hold       <= tx.tx_data;
        hold_last  <= tx.tx_last;
        hold_valid <= 1'b1;
      end else if (take_hold) begin
        hold_valid <= 1'b0;
      end

      if (load_sync) begin
        sh      <= {1'b0, SYNC_BYTE[7:1]};
        sh_cnt  <= 4'd7;
        sh_last <= 1'b0;
      end else if (take_hold) begin
        sh      <= hold_send ? {1'b0, hold[7:1]} : hold;
        sh_cnt  <= hold_send ? 4'd7 : 4'd8;
        sh_last <= hold_last;
      end else if (pop) begin
        sh     <= {1'b0, sh[7:1]};
        sh_cnt <= sh_cnt - 4'd1;
      end

      if (eop_load)     eop_cnt <= eop_val;
      else if (eop_dec) eop_cnt <= eop_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_usb_tx.sv
// Self-checking bench for usb_tx: per-cycle line comparison against a bit-level packet model.
module tb_usb_tx;

  localparam int CLKS = 4;
  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  logic clk48 = 1'b0;
  logic rst_n = 1'b0;
  logic usb_dp_out, usb_dn_out, usb_oe, tx_busy, tx_underrun;

  usb_tx_if tx_if ();

  usb_tx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk48       (clk48),
    .rst_n       (rst_n),
    .tx          (tx_if),
    .usb_dp_out  (usb_dp_out),
    .usb_dn_out  (usb_dn_out),
    .usb_oe      (usb_oe),
    .tx_busy     (tx_busy),
    .tx_underrun (tx_underrun)
  );

  always #5 clk48 = ~clk48;

  int errors = 0;
  int checks = 0;

  logic [7:0] pkt[$];
  logic [1:0] sym_q[$];
  int         ends_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bit-time line symbols for SYNC + pkt + EOP, and the stuffed position of each byte's last data bit.
  task automatic build_model();
    int ones;
    logic lv;
    logic [7:0] by;
    sym_q.delete();
    ends_q.delete();
    ones = 0;
    lv   = 1'b1;
    for (int k = -1; k < pkt.size(); k++) begin
      by = (k < 0) ? 8'h80 : pkt[k];
      for (int i = 0; i < 8; i++) begin
        if (!by[i]) lv = !lv;
        sym_q.push_back(lv ? SYM_J : SYM_K);
        ones = by[i] ? ones + 1 : 0;
        if (i == 7) ends_q.push_back(sym_q.size() - 1);
        if (ones == 6) begin
          lv = !lv;
          sym_q.push_back(lv ? SYM_J : SYM_K);
          ones = 0;
        end
      end
    end
    sym_q.push_back(SYM_SE0);
    sym_q.push_back(SYM_SE0);
    sym_q.push_back(SYM_J);
  endtask

  task automatic drive_next(input int idx, input int n, input bit with_last);
    if (idx < n) begin
      tx_if.tx_data  = pkt[idx];
      tx_if.tx_last  = with_last && (idx == n - 1);
      tx_if.tx_valid = 1'b1;
    end else begin
      tx_if.tx_valid = 1'b0;
      tx_if.tx_last  = 1'b0;
    end
  endtask

  task automatic run_packet(input bit with_last, input string tag);
    int n, idx, nsym, total, eop_c;
    logic [4:0] exp_v;
    logic [1:0] s;
    logic fire;
    build_model();
    n     = pkt.size();
    nsym  = sym_q.size();
    total = nsym * CLKS;
    eop_c = (nsym - 3) * CLKS;
    @(negedge clk48);
    drive_next(0, n, with_last);
    chk($sformatf("%s_ready_idle", tag), {31'd0, tx_if.tx_ready}, 32'd1);
    @(posedge clk48);
    #1;
    idx = 1;
    drive_next(idx, n, with_last);
    for (int c = 0; c < total + 2; c++) begin
      @(negedge clk48);
      if (c < total) begin
        s     = sym_q[c / CLKS];
        exp_v = {1'b1, s, 1'b1, (!with_last && c == eop_c)};
      end else begin
        exp_v = {1'b0, SYM_J, 1'b0, 1'b0};
      end
      chk($sformatf("%s_line_c%0d", tag, c),
          {27'd0, usb_oe, usb_dp_out, usb_dn_out, tx_busy, tx_underrun}, {27'd0, exp_v});
      if (c >= eop_c)
        chk($sformatf("%s_ready_eop_c%0d", tag, c), {31'd0, tx_if.tx_ready}, (c >= total) ? 32'd1 : 32'd0);
      fire = tx_if.tx_valid && tx_if.tx_ready;
      if (fire) begin
        chk($sformatf("%s_accept_b%0d", tag, idx), c, CLKS * (ends_q[idx - 1] + 1));
        idx++;
      end
      @(posedge clk48);
      #1;
      if (fire) drive_next(idx, n, with_last);
    end
    chk($sformatf("%s_all_accepted", tag), idx, n);
    tx_if.tx_valid = 1'b0;
    tx_if.tx_last  = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    tx_if.tx_data  = 8'd0;
    tx_if.tx_last  = 1'b0;
    tx_if.tx_valid = 1'b0;

    repeat (3) @(negedge clk48);
    chk("reset_outputs", {27'd0, usb_oe, usb_dp_out, usb_dn_out, tx_busy, tx_underrun}, 32'b01000);
    chk("reset_ready", {31'd0, tx_if.tx_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {31'd0, tx_if.tx_ready}, 32'd0);
    @(negedge clk48);
    chk("ready_after_edge", {31'd0, tx_if.tx_ready}, 32'd1);

    pkt = '{8'h00};
    run_packet(1'b1, "p00");
    pkt = '{8'hFF};
    run_packet(1'b1, "pFF");
    pkt = '{8'hA5, 8'h3C};
    run_packet(1'b1, "pA5_3C");
    pkt = '{8'h2D};
    run_packet(1'b0, "p2D_underrun");

    // Reset asserted during the third data bit of a 0x00 packet.
    @(negedge clk48);
    tx_if.tx_data  = 8'h00;
    tx_if.tx_last  = 1'b1;
    tx_if.tx_valid = 1'b1;
    @(posedge clk48);
    #1;
    tx_if.tx_valid = 1'b0;
    repeat (41) @(negedge clk48);
    chk("pre_reset_oe", {31'd0, usb_oe}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {27'd0, usb_oe, usb_dp_out, usb_dn_out, tx_busy, tx_underrun}, 32'b01000);
    chk("midreset_ready", {31'd0, tx_if.tx_ready}, 32'd0);
    repeat (2) @(negedge clk48);
    rst_n = 1'b1;
    @(negedge clk48);
    chk("post_reset_ready", {31'd0, tx_if.tx_ready}, 32'd1);
    pkt = '{8'h00};
    run_packet(1'b1, "p00_after_reset");

    pkt = '{8'h7F, 8'h80};
    run_packet(1'b1, "p7F_80");

    for (int p = 0; p < 6; p++) begin
      n = $urandom_range(1, 4);
      pkt.delete();
      for (int b = 0; b < n; b++) pkt.push_back(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk48);
      run_packet(1'b1, $sformatf("rand%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
